// File: rtl/multi_digit_7seg_scan_if.sv
// Host-side bundle for the multiplexed 7-segment driver: the value/strobe/mode inputs
// and the busy flag plus the active-low pin outputs.
interface multi_digit_7seg_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14
);
  logic [VALUE_W-1:0]    value;
  logic                  update;
  logic                  blank_lz;
  logic                  blink;
  logic                  busy;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;

  modport master (output value, update, blank_lz, blink, input  busy, seg, an);
  modport slave  (input  value, update, blank_lz, blink, output busy, seg, an);
endinterface

// File: rtl/multi_digit_7seg_scan.sv
// N-digit multiplexed 7-segment driver: sequential double-dabble binary->BCD, digit scan
// with leading-zero blanking, overflow dashes and a blink mode.

module dd_nibble_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module multi_digit_7seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_W     = 14,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_SCANS = 64
) (
  input logic                     clk,
  input logic                     rst,
  multi_digit_7seg_scan_if.slave  bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RC_W  = $clog2(REFRESH_DIV);
  localparam int BC_W  = $clog2(BLINK_SCANS + 1);
  localparam int SC_W  = $clog2(VALUE_W + 1);

  function automatic longint pow10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam logic [VALUE_W-1:0] MAX_VAL  = VALUE_W'(pow10(NUM_DIGITS) - 1);
  localparam logic [RC_W-1:0]    RC_LAST  = RC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BC_W-1:0]    BC_LAST  = BC_W'(BLINK_SCANS - 1);
  localparam logic [SC_W-1:0]    SC_LAST  = SC_W'(VALUE_W - 1);

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t                      state_q, state_d;
  logic [VALUE_W-1:0]          shreg;
  logic [NUM_DIGITS-1:0][3:0]  scratch, scratch_adj, bcd_q;
  logic [SC_W-1:0]             bit_cnt;
  logic                        ovf_next, ovf_q;

  logic [RC_W-1:0]             ref_cnt;
  logic [IDX_W-1:0]            idx;
  logic [BC_W-1:0]             blink_cnt;
  logic                        blink_on;
  logic                        ref_tc, scan_wrap;
  logic [NUM_DIGITS-1:0]       zero_from, sel_oh, an_d;
  logic                        zero_acc, digit_blank;
  logic [6:0]                  seg_d;

  // ---------------- conversion ----------------
  genvar g;
  for (g = 0; g < NUM_DIGITS; g++) begin : g_adj
    dd_nibble_adj u_adj (.d(scratch[g]), .q(scratch_adj[g]));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.update)         state_d = S_SHIFT;
      S_SHIFT:  if (bit_cnt == SC_LAST) state_d = S_COMMIT;
      S_COMMIT:                         state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // Display regs only change in COMMIT, so the scan never sees a half-converted value.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      scratch  <= '0;
      bit_cnt  <= '0;
      ovf_next <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.update) begin
          shreg    <= bus.value;
          scratch  <= '0;
          bit_cnt  <= '0;
          ovf_next <= (bus.value > MAX_VAL);
        end
        S_SHIFT: begin
          {scratch, shreg} <= {scratch_adj, shreg} << 1;
          bit_cnt          <= bit_cnt + SC_W'(1);
        end
        S_COMMIT: begin
          bcd_q <= scratch;
          ovf_q <= ovf_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != S_IDLE);

  // ---------------- scan / blink ----------------
  assign ref_tc    = (ref_cnt == RC_LAST);
  assign scan_wrap = ref_tc && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt   <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      bus.an    <= '1;
      bus.seg   <= 7'h7F;
    end else begin
      ref_cnt <= ref_tc ? '0 : ref_cnt + RC_W'(1);
      if (ref_tc) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      if (!bus.blink) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (scan_wrap) begin
        if (blink_cnt == BC_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + BC_W'(1);
        end
      end
      bus.an  <= an_d;
      bus.seg <= seg_d;
    end
  end

  // zero_from[k]: every BCD digit from k up to the top is zero.
  always_comb begin
    zero_from = '0;
    zero_acc  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_acc     = zero_acc & (bcd_q[k] == 4'd0);
      zero_from[k] = zero_acc;
    end
  end

  assign sel_oh      = NUM_DIGITS'(1) << idx;
  assign digit_blank = bus.blank_lz && (idx != '0) && zero_from[idx];

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    if (!(bus.blink && !blink_on)) begin
      if (ovf_q) begin
        an_d  = ~sel_oh;
        seg_d = 7'h3F;
      end else if (!digit_blank) begin
        an_d  = ~sel_oh;
        seg_d = decode(bcd_q[idx]);
      end
    end
  end
endmodule
